tlp_credit_scheduler: RTL and testbench
=======================================

# tlp_credit_scheduler

Sequencing controller for the shared up/down credit counter in the TLP detector datapath. It arbitrates between a consumer (takes one credit per grant, counter up) and a releaser (returns one credit per grant, counter down), drives the counter's enable/up controls, and protects against overflow past LIMIT and underflow below zero. It also runs a flush sequence that drains the counter to zero, and it keeps a saturating stall statistic.

## Interface
- WIDTH, 8, counter width; must match the attached counter.
- LIMIT, 200, maximum outstanding credits; 1 ≤ LIMIT ≤ 2^WIDTH−1.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  reset, asynchronous, active-low.
- cons_req  in  1  consumer requests one credit this cycle.
- cons_gnt  out  1  consumer granted; combinational, same cycle as request.
- rel_req  in  1  releaser returns one credit this cycle.
- rel_gnt  out  1  releaser granted; combinational, same cycle as request.
- flush_req  in  1  request drain of counter to zero; sampled in RUN only.
- flush_done  out  1  one-cycle pulse when drain completes.
- cnt_enable  out  1  to counter enable.
- cnt_up  out  1  to counter up (1 = increment, 0 = decrement).
- cnt_value  in  WIDTH  current counter value (counter output).
- full  out  1  cnt_value ≥ LIMIT.
- empty  out  1  cnt_value == 0.
- underflow_err  out  1  sticky; set on a refused lone release at zero; cleared only by reset.
- stall_cnt  out  WIDTH  saturating count of cycles with cons_req refused; cleared only by reset.

## Operation
- FSM states: INIT, RUN, FLUSH, DONE. Reset → INIT.
  - INIT → RUN unconditionally after one cycle; grants forced 0 in INIT.
  - RUN → FLUSH when flush_req=1.
  - FLUSH → DONE when cnt_value==0.
  - DONE → RUN unconditionally.
- RUN arbitration, evaluated combinationally from cnt_value, with flush_req=0:
  - cons_req only, not full: cons_gnt=1; cnt_enable=1, cnt_up=1.
  - cons_req only, full: refused; stall_cnt increments.
  - rel_req only, not empty: rel_gnt=1; cnt_enable=1, cnt_up=0.
  - rel_req only, empty: refused; underflow_err set at next edge.
  - Both requests, cnt_value > 0: both granted (credit swap). Net change is zero, so cnt_enable=0. This holds when full.
  - Both requests, cnt_value == 0: cons granted alone; cnt_enable=1, cnt_up=1. Release is refused, with no error and no stall.
- RUN with flush_req=1: both grants 0 this cycle (flush has priority); refused cons_req still counts as a stall.
- FLUSH:
  - All grants 0.
  - While cnt_value ≠ 0: cnt_enable=1, cnt_up=0.
  - Refused cons_req increments stall_cnt.
  - flush_req is ignored.
- DONE: flush_done=1, grants 0, cnt_enable=0.
- Outputs other than stall_cnt and underflow_err are decoded from the state register and cnt_value; there is no extra register stage.
- stall_cnt saturates at 2^WIDTH−1 and does not wrap.
- cnt_enable is never 1 when an increment would exceed LIMIT or a decrement would go below 0.

## Timing
- Reset values:
  - State INIT; stall_cnt 0; underflow_err 0.
  - cons_gnt, rel_gnt, cnt_enable, cnt_up, flush_done all 0.
  - full and empty follow cnt_value; the counter resets to 0, so empty=1 and full=0.
- Grant latency is zero cycles: grant and cnt_enable assert in the request cycle, and the counter reflects the change at the next rising edge.
- The first grant is possible in cycle 2 after reset deasserts (cycle 1 is INIT).
- Flush from cnt_value=N: one RUN cycle with flush_req, then N FLUSH cycles decrementing, then one FLUSH cycle seeing 0, then DONE. flush_done asserts N+2 cycles after the flush_req edge; with N=0 it asserts 2 cycles after.
- Reset mid-flush: return to INIT immediately (asynchronous). The counter is also reset by the same reset.

## Test plan
- Reset, then cons_req=1 held for 202 cycles with LIMIT=200 → first grant in cycle 2; cnt_value reaches 200; full=1; the last 1 cycle of requests is refused and stall_cnt=1.
- At cnt_value=200, assert cons_req and rel_req together → both granted, cnt_enable=0, cnt_value stays 200.
- At cnt_value=0, rel_req alone for 1 cycle → rel_gnt=0, cnt_enable=0, underflow_err=1 and stays 1 afterward.
- At cnt_value=5, pulse flush_req while cons_req=1 → no grants; cnt_value steps 5,4,3,2,1,0; flush_done pulses exactly once, 7 cycles after the request edge; RUN grants resume the following cycle.
- Assert reset during FLUSH at cnt_value=3 → all outputs immediately at reset values; after release, one INIT cycle, then normal grants.
- WIDTH=4, LIMIT=15, cons_req held for 40 cycles at full → stall_cnt saturates at 15.

Source files
------------

// File: rtl/tlp_credit_scheduler.sv
// Credit counter sequencer: arbitrates consume/release requests onto a shared
// up/down counter, guards LIMIT and zero, drains on flush, counts refused consumes.
module tlp_credit_scheduler #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cons_req,
    output logic             cons_gnt,
    input  logic             rel_req,
    output logic             rel_gnt,
    input  logic             flush_req,
    output logic             flush_done,
    output logic             cnt_enable,
    output logic             cnt_up,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             full,
    output logic             empty,
    output logic             underflow_err,
    output logic [WIDTH-1:0] stall_cnt,
    output logic [1:0]       state_dbg
);

    // Request/grant: a request is taken only in the cycle its grant is high;
    // an ungranted request is dropped, so a requester retries by holding req.
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] stall_q, stall_d;
    logic             uflow_q, uflow_d;
    logic             stall_inc;

    assign full          = (cnt_value >= LIMIT_W);
    assign empty         = (cnt_value == '0);
    assign underflow_err = uflow_q;
    assign stall_cnt     = stall_q;
    assign state_dbg     = state_q;

    always_comb begin
        state_d    = state_q;
        uflow_d    = uflow_q;
        stall_inc  = 1'b0;
        cons_gnt   = 1'b0;
        rel_gnt    = 1'b0;
        cnt_enable = 1'b0;
        cnt_up     = 1'b0;
        flush_done = 1'b0;
        case (state_q)
            ST_INIT: state_d = ST_RUN;
            ST_RUN: begin
                if (flush_req) begin
                    state_d   = ST_FLUSH;
                    stall_inc = cons_req;
                end else if (cons_req && rel_req) begin
                    cons_gnt = 1'b1;
                    if (!empty) begin
                        // Swap: one in, one out, counter holds its value.
                        rel_gnt = 1'b1;
                    end else begin
                        cnt_enable = 1'b1;
                        cnt_up     = 1'b1;
                    end
                end else if (cons_req) begin
                    if (!full) begin
                        cons_gnt   = 1'b1;
                        cnt_enable = 1'b1;
                        cnt_up     = 1'b1;
                    end else begin
                        stall_inc = 1'b1;
                    end
                end else if (rel_req) begin
                    if (!empty) begin
                        rel_gnt    = 1'b1;
                        cnt_enable = 1'b1;
                    end else begin
                        uflow_d = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                stall_inc = cons_req;
                if (!empty) cnt_enable = 1'b1;
                else        state_d    = ST_DONE;
            end
            ST_DONE: begin
                flush_done = 1'b1;
                state_d    = ST_RUN;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (stall_inc && (stall_q != '1)) stall_d = stall_q + WIDTH'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
            stall_q <= '0;
            uflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            uflow_q <= uflow_d;
        end
    end

endmodule

// File: tb/tb_tlp_credit_scheduler.sv
// Directed bench for tlp_credit_scheduler: an attached up/down counter model,
// one task per scenario, inline comparisons and a one-line summary.
module tb_tlp_credit_scheduler;

    logic       clk;
    int         errors = 0;
    int         checks = 0;

    // Instance 1: WIDTH=8, LIMIT=200
    logic       rst1_n, cons1, rel1, flush1;
    logic       cgnt1, rgnt1, fdone1, en1, up1, full1, empty1, uflow1;
    logic [7:0] cnt1, stall1;
    logic [1:0] st1;

    // Instance 2: WIDTH=4, LIMIT=15
    logic       rst2_n, cons2, rel2, flush2;
    logic       cgnt2, rgnt2, fdone2, en2, up2, full2, empty2, uflow2;
    logic [3:0] cnt2, stall2;
    logic [1:0] st2;

    tlp_credit_scheduler #(.WIDTH(8), .LIMIT(200)) dut1 (
        .clk(clk), .reset(rst1_n), .cons_req(cons1), .cons_gnt(cgnt1),
        .rel_req(rel1), .rel_gnt(rgnt1), .flush_req(flush1), .flush_done(fdone1),
        .cnt_enable(en1), .cnt_up(up1), .cnt_value(cnt1), .full(full1),
        .empty(empty1), .underflow_err(uflow1), .stall_cnt(stall1), .state_dbg(st1)
    );

    tlp_credit_scheduler #(.WIDTH(4), .LIMIT(15)) dut2 (
        .clk(clk), .reset(rst2_n), .cons_req(cons2), .cons_gnt(cgnt2),
        .rel_req(rel2), .rel_gnt(rgnt2), .flush_req(flush2), .flush_done(fdone2),
        .cnt_enable(en2), .cnt_up(up2), .cnt_value(cnt2), .full(full2),
        .empty(empty2), .underflow_err(uflow2), .stall_cnt(stall2), .state_dbg(st2)
    );

    // Clock and the attached counters (reset by the same reset as the scheduler)
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst1_n) begin
        if (!rst1_n)  cnt1 <= '0;
        else if (en1) cnt1 <= up1 ? cnt1 + 8'd1 : cnt1 - 8'd1;
    end

    always_ff @(posedge clk or negedge rst2_n) begin
        if (!rst2_n)  cnt2 <= '0;
        else if (en2) cnt2 <= up2 ? cnt2 + 4'd1 : cnt2 - 4'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst1_n = 1'b0; rst2_n = 1'b0;
        cons1 = 1'b1; rel1 = 1'b0; flush1 = 1'b0;
        cons2 = 1'b0; rel2 = 1'b0; flush2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({cgnt1, rgnt1, en1, up1, fdone1} !== 5'b0) begin
            errors++; $display("FAIL reset_ctl: got %b want 00000", {cgnt1, rgnt1, en1, up1, fdone1});
        end
        checks++;
        if ({full1, empty1, uflow1} !== 3'b010) begin
            errors++; $display("FAIL reset_flags: got %b want 010", {full1, empty1, uflow1});
        end
        checks++;
        if (stall1 !== 8'd0) begin
            errors++; $display("FAIL reset_stall: got %0d want 0", stall1);
        end
        checks++;
        if (st1 !== 2'd0) begin
            errors++; $display("FAIL reset_state: got %0d want 0", st1);
        end
        rst1_n = 1'b1;
    endtask

    task automatic test_fill();
        int bad_gnt = 0;
        int bad_cnt = 0;
        #1;
        checks++;
        if (cgnt1 !== 1'b0) begin
            errors++; $display("FAIL fill_init_gnt: got %b want 0", cgnt1);
        end
        for (int c = 2; c <= 201; c++) begin
            tick();
            checks++;
            if ({cgnt1, en1, up1} !== 3'b111) begin
                errors++; bad_gnt++;
                if (bad_gnt < 4) $display("FAIL fill_gnt cycle %0d: got %b want 111", c, {cgnt1, en1, up1});
            end
            checks++;
            if (cnt1 !== 8'(c - 2)) begin
                errors++; bad_cnt++;
                if (bad_cnt < 4) $display("FAIL fill_cnt cycle %0d: got %0d want %0d", c, cnt1, c - 2);
            end
        end
        tick();
        checks++;
        if ({cgnt1, en1, full1} !== 3'b001) begin
            errors++; $display("FAIL fill_refuse: got %b want 001", {cgnt1, en1, full1});
        end
        checks++;
        if (cnt1 !== 8'd200) begin
            errors++; $display("FAIL fill_top: got %0d want 200", cnt1);
        end
        tick();
        cons1 = 1'b0;
        checks++;
        if (stall1 !== 8'd1) begin
            errors++; $display("FAIL fill_stall: got %0d want 1", stall1);
        end
    endtask

    task automatic test_swap();
        cons1 = 1'b1; rel1 = 1'b1;
        #1;
        checks++;
        if ({cgnt1, rgnt1, en1} !== 3'b110) begin
            errors++; $display("FAIL swap_full: got %b want 110", {cgnt1, rgnt1, en1});
        end
        tick();
        cons1 = 1'b0; rel1 = 1'b0;
        checks++;
        if ({cnt1, stall1} !== {8'd200, 8'd1}) begin
            errors++; $display("FAIL swap_hold: got cnt %0d stall %0d want 200 1", cnt1, stall1);
        end
    endtask

    task automatic test_flush_full();
        int got = -1;
        flush1 = 1'b1;
        #1;
        checks++;
        if ({cgnt1, rgnt1, en1} !== 3'b000) begin
            errors++; $display("FAIL flush200_req: got %b want 000", {cgnt1, rgnt1, en1});
        end
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 1) flush1 = 1'b0;
            if (fdone1 === 1'b1) begin
                got = i;
                break;
            end
        end
        checks++;
        if (got != 202) begin
            errors++; $display("FAIL flush200_latency: got %0d want 202", got);
        end
        checks++;
        if ({cnt1, st1} !== {8'd0, 2'd3}) begin
            errors++; $display("FAIL flush200_done: got cnt %0d state %0d want 0 3", cnt1, st1);
        end
        tick();
        checks++;
        if ({fdone1, st1} !== {1'b0, 2'd1}) begin
            errors++; $display("FAIL flush200_run: got done %b state %0d want 0 1", fdone1, st1);
        end
    endtask

    task automatic test_underflow();
        rel1 = 1'b1;
        #1;
        checks++;
        if ({rgnt1, en1} !== 2'b00) begin
            errors++; $display("FAIL uflow_gnt: got %b want 00", {rgnt1, en1});
        end
        tick();
        rel1 = 1'b0;
        tick();
        checks++;
        if ({uflow1, cnt1} !== {1'b1, 8'd0}) begin
            errors++; $display("FAIL uflow_sticky: got err %b cnt %0d want 1 0", uflow1, cnt1);
        end
        cons1 = 1'b1; rel1 = 1'b1;
        #1;
        checks++;
        if ({cgnt1, rgnt1, en1, up1} !== 4'b1011) begin
            errors++; $display("FAIL both_at_zero: got %b want 1011", {cgnt1, rgnt1, en1, up1});
        end
        tick();
        cons1 = 1'b0; rel1 = 1'b0;
        checks++;
        if ({cnt1, stall1} !== {8'd1, 8'd1}) begin
            errors++; $display("FAIL both_at_zero_after: got cnt %0d stall %0d want 1 1", cnt1, stall1);
        end
        rel1 = 1'b1;
        #1;
        checks++;
        if ({rgnt1, en1, up1} !== 3'b110) begin
            errors++; $display("FAIL rel_one: got %b want 110", {rgnt1, en1, up1});
        end
        tick();
        rel1 = 1'b0;
        checks++;
        if ({cnt1, uflow1} !== {8'd0, 1'b1}) begin
            errors++; $display("FAIL rel_one_after: got cnt %0d err %b want 0 1", cnt1, uflow1);
        end
    endtask

    task automatic test_flush_five();
        int got = -1;
        cons1 = 1'b1;
        repeat (5) tick();
        flush1 = 1'b1;
        #1;
        checks++;
        if ({cnt1, cgnt1, rgnt1, en1} !== {8'd5, 3'b000}) begin
            errors++; $display("FAIL flush5_req: got cnt %0d ctl %b want 5 000", cnt1, {cgnt1, rgnt1, en1});
        end
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) flush1 = 1'b0;
            if (fdone1 === 1'b1) begin
                got = i;
                break;
            end
            if (i <= 6) begin
                checks++;
                if ({cnt1, cgnt1, st1} !== {8'(6 - i), 1'b0, 2'd2}) begin
                    errors++;
                    $display("FAIL flush5_step %0d: got cnt %0d gnt %b state %0d want %0d 0 2", i, cnt1, cgnt1, st1, 6 - i);
                end
            end
        end
        checks++;
        if (got != 7) begin
            errors++; $display("FAIL flush5_latency: got %0d want 7", got);
        end
        checks++;
        if ({cgnt1, stall1} !== {1'b0, 8'd8}) begin
            errors++; $display("FAIL flush5_stall: got gnt %b stall %0d want 0 8", cgnt1, stall1);
        end
        tick();
        checks++;
        if ({fdone1, cgnt1, stall1} !== {2'b01, 8'd8}) begin
            errors++; $display("FAIL flush5_resume: got done %b gnt %b stall %0d want 0 1 8", fdone1, cgnt1, stall1);
        end
    endtask

    task automatic test_reset_mid_flush();
        repeat (3) tick();
        cons1 = 1'b0; flush1 = 1'b1;
        tick();
        flush1 = 1'b0;
        checks++;
        if ({st1, cnt1, en1} !== {2'd2, 8'd3, 1'b1}) begin
            errors++; $display("FAIL midflush_state: got state %0d cnt %0d en %b want 2 3 1", st1, cnt1, en1);
        end
        #2;
        rst1_n = 1'b0;
        #1;
        checks++;
        if ({st1, cnt1, cgnt1, rgnt1, en1, up1, fdone1} !== {2'd0, 8'd0, 5'b0}) begin
            errors++; $display("FAIL midflush_reset: got state %0d cnt %0d ctl %b want 0 0 00000", st1, cnt1, {cgnt1, rgnt1, en1, up1, fdone1});
        end
        checks++;
        if ({stall1, uflow1, empty1, full1} !== {8'd0, 3'b010}) begin
            errors++; $display("FAIL midflush_regs: got stall %0d flags %b want 0 010", stall1, {uflow1, empty1, full1});
        end
        cons1 = 1'b1;
        @(posedge clk);
        #1;
        rst1_n = 1'b1;
        #1;
        checks++;
        if (cgnt1 !== 1'b0) begin
            errors++; $display("FAIL midflush_init: got %b want 0", cgnt1);
        end
        tick();
        checks++;
        if ({cgnt1, st1} !== {1'b1, 2'd1}) begin
            errors++; $display("FAIL midflush_grant: got gnt %b state %0d want 1 1", cgnt1, st1);
        end
        cons1 = 1'b0;
    endtask

    task automatic test_saturate();
        cons2 = 1'b1;
        rst2_n = 1'b1;
        for (int c = 2; c <= 40; c++) tick();
        tick();
        cons2 = 1'b0;
        checks++;
        if ({cnt2, full2} !== {4'd15, 1'b1}) begin
            errors++; $display("FAIL sat_cnt: got cnt %0d full %b want 15 1", cnt2, full2);
        end
        checks++;
        if (stall2 !== 4'd15) begin
            errors++; $display("FAIL sat_stall: got %0d want 15", stall2);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_swap();
        test_flush_full();
        test_underflow();
        test_flush_five();
        test_reset_mid_flush();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
